// File: rtl/uart_tx_buffer.sv
// Buffered UART transmitter: a small FIFO absorbs push strobes and the FSM drains it as 8N1 frames.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_buffer #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_ready,
  input  logic [7:0]            sdata,
  output logic                  txd,
  output logic                  busy,
  output logic                  full,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]       CNT_LAST   = CW'(CLK_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state_r, state_n;
  logic [CW-1:0]         cnt_r, cnt_n;
  logic [2:0]            bit_idx_r, bit_idx_n;
  logic [7:0]            shift_r, shift_n;
  logic                  txd_r, txd_n;
  logic [DEPTH_LOG2-1:0] wptr_r, rptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  overflow_r;
  logic [7:0]            mem_r [DEPTH];
  logic                  pop_s, push_s, full_s, bit_end_s;
  logic [7:0]            head_s;

`ifdef UART_TX_PARITY_EN
  logic                  par_r, par_n;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign full_s    = (count_r == FULL_COUNT);
  assign bit_end_s = (cnt_r == CNT_LAST);
  assign head_s    = mem_r[rptr_r];
  // A full FIFO still accepts a push when the FSM frees a slot on the same edge.
  assign push_s    = tx_ready & (~full_s | pop_s);

  assign txd      = txd_r;
  assign overflow = overflow_r;
  assign count    = count_r;
  assign full     = full_s;
  assign busy     = (state_r != IDLE) | (count_r != {(DEPTH_LOG2+1){1'b0}});

  // Frame sequencing: next state, baud counter, shift register and next txd level.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    txd_n     = txd_r;
    pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n     = par_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_n = {CW{1'b0}};
        txd_n = 1'b1;
        if (count_r != {(DEPTH_LOG2+1){1'b0}}) begin
          pop_s   = 1'b1;
          shift_n = head_s;
`ifdef UART_TX_PARITY_EN
          par_n   = even_parity(head_s);
`endif
          txd_n   = 1'b0;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_n     = {CW{1'b0}};
          txd_n     = shift_r[0];
          bit_idx_n = 3'd0;
          state_n   = DATA;
        end else begin
          cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_n     = {CW{1'b0}};
          shift_n   = {1'b0, shift_r[7:1]};
          bit_idx_n = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_n   = par_r;
            state_n = PARITY;
`else
            txd_n   = 1'b1;
            state_n = STOP;
`endif
          end else begin
            txd_n = shift_r[1];
          end
        end else begin
          cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          cnt_n   = {CW{1'b0}};
          txd_n   = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
`endif
      STOP: begin
        txd_n = 1'b1;
        if (bit_end_s) begin
          cnt_n = {CW{1'b0}};
          // Back-to-back frames: load the next byte without an idle bit.
          if (count_r != {(DEPTH_LOG2+1){1'b0}}) begin
            pop_s   = 1'b1;
            shift_n = head_s;
`ifdef UART_TX_PARITY_EN
            par_n   = even_parity(head_s);
`endif
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cnt_n   = {CW{1'b0}};
        txd_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and FIFO bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      txd_r      <= 1'b1;
      wptr_r     <= {DEPTH_LOG2{1'b0}};
      rptr_r     <= {DEPTH_LOG2{1'b0}};
      count_r    <= {(DEPTH_LOG2+1){1'b0}};
      overflow_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
      txd_r     <= txd_n;
`ifdef UART_TX_PARITY_EN
      par_r     <= par_n;
`endif
      if (push_s) wptr_r <= wptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      if (pop_s)  rptr_r <= rptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (tx_ready && !push_s) overflow_r <= 1'b1;
    end
  end

  // FIFO storage; stale contents are harmless because pointers reset.
  always_ff @(posedge clk) begin
    if (rstn && push_s) mem_r[wptr_r] <= sdata;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Serial output stage downstream of the multicycle core's transmit instruction. The core pulses tx_ready for one cycle with the byte on sdata and never stalls, so this block absorbs bursts in a small FIFO. It serializes each byte onto txd as 8N1 UART frames at a fixed bit period. Its status outputs are for the top level or LEDs; there is no back-pressure to the core.

Parameters:
CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal values ≥ 2.
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes.

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
tx_ready  in  1  one-cycle push strobe from core
sdata  in  8  byte to send, valid when tx_ready=1
txd  out  1  UART serial line, idle high, registered
busy  out  1  1 while FIFO non-empty or a frame is in progress
full  out  1  FIFO count == 2**DEPTH_LOG2
overflow  out  1  sticky: a push was dropped
count  out  DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset, sampled on posedge clk with rstn=0:
  - txd=1, state=IDLE, count=0, read/write pointers=0, overflow=0, baud counter=0, bit index=0.
  - busy and full follow combinationally from that state, so both are 0.
  - Reset mid-frame aborts the frame; txd=1 from the next edge; FIFO contents are discarded.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers that wrap naturally; count is tracked separately.
  - Push: tx_ready=1 at an edge, and either count<DEPTH or a pop occurs on the same edge. sdata is written at wptr; wptr increments.
  - Push while full with no same-edge pop: byte is dropped, overflow set to 1, overflow stays 1 until reset.
  - Pop: occurs only when the FSM loads a byte (see below); rptr increments.
  - Push and pop on the same edge: count unchanged.
  - A push into an empty FIFO is not visible to the FSM until the following edge. There is no first-word fall-through.
- FSM states: IDLE, START, DATA, STOP. The baud counter cnt counts 0..CLK_PER_BIT-1; a bit ends on the edge where cnt==CLK_PER_BIT-1.
  - IDLE: txd=1. If count≠0: pop FIFO[rptr] into the shift register, txd<=0, cnt<=0, go to START.
  - START: at bit end, txd<=shift[0], bit index<=0, go to DATA.
  - DATA: at each bit end, shift right and increment bit index. If bit index was 7: txd<=1 and go to STOP; otherwise txd<=next bit.
  - STOP: txd=1. At bit end: if count≠0, pop and load, txd<=0, go to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Bit order: LSB first.
- Frame length: exactly 10*CLK_PER_BIT cycles.
- Latency: tx_ready sampled at edge E0 into an idle, empty block → txd falls at edge E0+1 and the start bit lasts CLK_PER_BIT cycles.
- busy = (state≠IDLE) | (count≠0).

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: adds state PARITY between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for CLK_PER_BIT cycles. Frame length becomes 11*CLK_PER_BIT cycles.
- Not defined: plain 8N1, no PARITY state, 10*CLK_PER_BIT cycle frames.

Test Plan:
1. CLK_PER_BIT=4. Reset, then push 0xA5 once. Expect txd=1 during reset. txd low 1 edge after the push for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles. busy=0 from the edge ending stop. overflow=0.
2. CLK_PER_BIT=4. Push 0x01, 0x02, 0x03 on consecutive cycles. Expect count peaks at 2. Three contiguous frames of 40 cycles each with no idle cycle between stop and next start; decoded bytes are 01,02,03.
3. DEPTH_LOG2=2, CLK_PER_BIT=8. Push 6 bytes on consecutive cycles. Expect the first byte is popped on its own, so 5 bytes remain for 4 slots. full=1 after 5 pushes. The 6th byte is dropped and overflow=1 and stays 1. Transmitted: bytes 1–5.
4. DEPTH_LOG2=2. Arrange count=4 and a push on the same edge that STOP pops. Expect the push is accepted, count stays 4, overflow=0.
5. Assert rstn=0 for one cycle during DATA with 3 bytes queued. Expect txd=1 next edge, count=0, busy=0, and no further frames.
6. With UART_TX_PARITY_EN, push 0x07. Expect parity bit 1 after data, stop bit follows, frame is 44 cycles at CLK_PER_BIT=4.
